// File: rtl/module_corrector_secded_pkg.sv
// Hamming SEC-DED helpers shared by the decoder and the future encoder:
// parity width, parity-position test, data-bit placement and error class.
package pkg_hamming;

   typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_class_t;

   function automatic int calc_par_w(input int data_w);
      int p;
      p = 1;
      while ((1 << p) < (data_w + p + 1)) p = p + 1;
      return p;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Hamming position of data bit k: the k-th position >= 3 that is not a power of two.
   function automatic int data_pos(input int k);
      int i;
      i = 2;
      for (int n = 0; n <= k; n++) begin
         i = i + 1;
         while (is_pow2(i)) i = i + 1;
      end
      return i;
   endfunction

endpackage

// File: rtl/module_corrector_secded_sindrome.sv
// Combinational syndrome and overall-parity calculator for an extended Hamming word.
// No latency, no flow control: pure function of the codeword.
module module_sindrome_secded
   import pkg_hamming::*;
#(
   parameter int DATA_W = 4,
   localparam int PAR_W = calc_par_w(DATA_W),
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic [CODE_W-1:0] code,
   output logic [PAR_W-1:0]  sindrome,
   output logic              p_err
);

   always_comb begin
      sindrome = '0;
      for (int i = 1; i < CODE_W; i++) begin
         for (int k = 0; k < PAR_W; k++) begin
            if (((i >> k) & 1) != 0) sindrome[k] = sindrome[k] ^ code[i];
         end
      end
   end

   assign p_err = ^code;

endmodule

// File: rtl/module_corrector_secded.sv
// Two-stage SEC-DED decoder on a valid/ready stream with saturating error counters.
// Latency 2 cycles, 1 word/cycle; stalls propagate upstream through in_ready, outputs hold while stalled.
module module_corrector_secded
   import pkg_hamming::*;
#(
   parameter int DATA_W = 4,
   parameter int CNT_W = 8,
   localparam int PAR_W = calc_par_w(DATA_W),
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [PAR_W-1:0]  out_sindrome,
   output logic              out_single,
   output logic              out_double,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   logic              s1_valid;
   logic [CODE_W-1:0] s1_code;
   logic [PAR_W-1:0]  s1_sind;
   logic              s1_perr;
   logic [PAR_W-1:0]  c_sind;
   logic              c_perr;
   logic              s1_adv;
   logic              s2_adv;
   logic              out_fire;
   err_class_t        cls;
   logic [CODE_W-1:0] fixed;
   logic [DATA_W-1:0] data_fix;

   module_sindrome_secded #(.DATA_W(DATA_W)) u_sind (
      .code     (in_code),
      .sindrome (c_sind),
      .p_err    (c_perr)
   );

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_sind  <= '0;
         s1_perr  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_code <= in_code;
            s1_sind <= c_sind;
            s1_perr <= c_perr;
         end
      end
   end

   // A parity error pointing past the last position cannot be a single flip.
   always_comb begin
      cls = CLEAN;
      if (s1_perr) cls = (int'(s1_sind) < CODE_W) ? SINGLE : DOUBLE;
      else if (s1_sind != '0) cls = DOUBLE;
   end

   always_comb begin
      fixed = s1_code;
      for (int i = 1; i < CODE_W; i++) begin
         if (cls == SINGLE && int'(s1_sind) == i) fixed[i] = !s1_code[i];
      end
   end

   for (genvar k = 0; k < DATA_W; k++) begin : g_dat
      assign data_fix[k] = fixed[data_pos(k)];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sindrome <= '0;
         out_single   <= 1'b0;
         out_double   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= data_fix;
            out_sindrome <= s1_sind;
            out_single   <= (cls == SINGLE);
            out_double   <= (cls == DOUBLE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (clr_cnt) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (out_fire) begin
         if (out_single && cnt_corr != '1)   cnt_corr   <= cnt_corr + 1'b1;
         if (out_double && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + 1'b1;
      end
   end

endmodule

// File: tb/tb_module_corrector_secded.sv
// Scoreboard bench for the SEC-DED decoder (DATA_W=4, CNT_W=2): directed codewords
// with hand-derived results, backpressure, counter saturation/clear and async reset.
module tb_module_corrector_secded;

   typedef struct packed {
      logic [3:0] d;
      logic [2:0] s;
      logic       sg;
      logic       db;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_sindrome;
   logic       out_single;
   logic       out_double;
   logic       clr_cnt;
   logic [1:0] cnt_corr;
   logic [1:0] cnt_uncorr;

   exp_t exp_q[$];
   int   n_chk;
   int   n_pass;
   int   n_acc;

   module_corrector_secded #(.DATA_W(4), .CNT_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sindrome (out_sindrome),
      .out_single   (out_single),
      .out_double   (out_double),
      .clr_cnt      (clr_cnt),
      .cnt_corr     (cnt_corr),
      .cnt_uncorr   (cnt_uncorr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] d, input logic [2:0] s, input logic sg, input logic db);
      exp_t e;
      e.d = d; e.s = s; e.sg = sg; e.db = db;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
      else n_pass++;
   endtask

   task automatic send(input logic [7:0] c, input exp_t e);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      exp_q.push_back(e);
      in_valid = 1'b1;
      in_code  = c;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         n_chk++;
         $display("FAIL accept_timeout: code %0h not accepted after %0d cycles", c, n);
      end else n_acc++;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      end
   endtask

   // Monitor: every presented output is checked against the head of the queue,
   // so a stalled word is re-checked each cycle until it is taken.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output: got data %0h with no word outstanding", out_data);
         end else begin
            chk("out_word", {23'd0, out_data, out_sindrome, out_single, out_double}, {23'd0, exp_q[0]});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_pass = 0; n_acc = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_cnt = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_outputs", {out_data, out_sindrome, out_single, out_double}, 0);
      chk("rst_counters", {cnt_corr, cnt_uncorr}, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean word and the 2-cycle latency
      send(8'b1010_1010, mk(4'b1011, 3'b000, 1'b0, 1'b0));
      chk("lat_cycle1_out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_cycle2_out_valid", out_valid, 1);
      drain();
      chk("clean_counters", {cnt_corr, cnt_uncorr}, 0);

      send(8'b1000_1010, mk(4'b1011, 3'b101, 1'b1, 1'b0));
      drain();
      chk("single_cnt_corr", cnt_corr, 1);
      send(8'b1010_1011, mk(4'b1011, 3'b000, 1'b1, 1'b0));
      send(8'b1000_0010, mk(4'b1000, 3'b110, 1'b0, 1'b1));
      drain();
      chk("after_par_dbl_cnt_corr", cnt_corr, 2);
      chk("after_dbl_cnt_uncorr", cnt_uncorr, 1);

      // Backpressure: four back-to-back words, consumer stalled for 3 cycles
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            send(8'h5A, mk(4'b0101, 3'b000, 1'b0, 1'b0));
            send(8'hF7, mk(4'b1111, 3'b011, 1'b1, 1'b0));
            send(8'h00, mk(4'b0000, 3'b000, 1'b0, 1'b0));
            send(8'h06, mk(4'b0000, 3'b011, 1'b0, 1'b1));
         end
         begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_accepted", n_acc, 2);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_accepted_total", n_acc, 4);
      chk("bp_cnt_corr", cnt_corr, 3);
      chk("bp_cnt_uncorr", cnt_uncorr, 2);

      // Plain clear, then saturation with CNT_W=2
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      chk("clr_counters", {cnt_corr, cnt_uncorr}, 0);
      for (int i = 0; i < 5; i++) send(8'hF7, mk(4'b1111, 3'b011, 1'b1, 1'b0));
      drain();
      chk("sat_cnt_corr", cnt_corr, 3);
      chk("sat_cnt_uncorr", cnt_uncorr, 0);

      // Clear coinciding with a single-error output handshake
      out_ready = 1'b0;
      send(8'hF7, mk(4'b1111, 3'b011, 1'b1, 1'b0));
      for (int n = 0; n < 20 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("clr_race_out_valid", out_valid, 1);
      out_ready = 1'b1;
      clr_cnt   = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      chk("clr_wins_cnt_corr", cnt_corr, 0);
      drain();

      // Asynchronous reset between edges while words are in flight
      send(8'h5A, mk(4'b0101, 3'b000, 1'b0, 1'b0));
      send(8'h00, mk(4'b0000, 3'b000, 1'b0, 1'b0));
      chk("mid_stream_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("no_stale_word", out_valid, 0);
      end
      send(8'hFF, mk(4'b1111, 3'b000, 1'b0, 1'b0));
      drain();
      chk("post_rst_counters", {cnt_corr, cnt_uncorr}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
